// File: rtl/lfu_pkg.sv
// Shared types, width helpers and event priority codes for the LFU replacement engine.
// Pure declarations, no logic, no latency.
// Not applicable: no handshaking lives here.
package lfu_pkg;

    // Index width for a count of n items, kept at least one bit wide.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Default geometry, so the index typedefs have a concrete width.
    localparam int DEF_WAYS = 4;
    localparam int DEF_SETS = 16;

    typedef logic [idx_width(DEF_WAYS)-1:0] way_idx_t;
    typedef logic [idx_width(DEF_SETS)-1:0] set_idx_t;

    // Per-way event codes. A larger code wins when several events hit the
    // same set and way in one cycle.
    typedef logic [1:0] ev_t;
    localparam ev_t EV_NONE = 2'd0;
    localparam ev_t EV_HIT  = 2'd1;
    localparam ev_t EV_FILL = 2'd2;
    localparam ev_t EV_INV  = 2'd3;

endpackage

// File: rtl/lfu_argmin.sv
// Victim pick over one set row: lowest invalid way first, else minimum counter, ties low.
// Purely combinational, zero latency.
// No backpressure: the result is valid whenever the inputs are.
// Ports: valid/cnt = per-way state of one set; way = chosen way; free = chosen way invalid.
module lfu_argmin
    import lfu_pkg::*;
#(
    parameter int NUM_WAYS  = 4,
    parameter int COUNTER_W = 4,
    localparam int WAY_W    = idx_width(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0]                valid,
    input  logic [NUM_WAYS-1:0][COUNTER_W-1:0] cnt,
    output logic [WAY_W-1:0]                   way,
    output logic                               free
);
    localparam int LVLS = $clog2(NUM_WAYS);

    // Key = {valid, counter}, with invalid ways forced to all zero. Every
    // invalid way then beats every valid way, and the counter decides among
    // valid ways.
    logic [COUNTER_W:0] key [LVLS+1][NUM_WAYS];
    logic [WAY_W-1:0]   idx [LVLS+1][NUM_WAYS];

    always_comb begin
        for (int l = 0; l <= LVLS; l++) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                key[l][i] = '0;
                idx[l][i] = '0;
            end
        end
        for (int i = 0; i < NUM_WAYS; i++) begin
            key[0][i] = valid[i] ? {1'b1, cnt[i]} : '0;
            idx[0][i] = WAY_W'(i);
        end
        // The right child wins only when it is strictly smaller, so ties
        // resolve to the lower index at every level.
        for (int l = 0; l < LVLS; l++) begin
            for (int i = 0; i < (NUM_WAYS >> (l + 1)); i++) begin
                if (key[l][2*i+1] < key[l][2*i]) begin
                    key[l+1][i] = key[l][2*i+1];
                    idx[l+1][i] = idx[l][2*i+1];
                end else begin
                    key[l+1][i] = key[l][2*i];
                    idx[l+1][i] = idx[l][2*i];
                end
            end
        end
        way  = idx[LVLS][0];
        free = ~key[LVLS][0][COUNTER_W];
    end

endmodule

// File: rtl/lfu_replacer.sv
// LFU replacement engine: per-set/way saturating use counters + valid bits, victim query.
// Query latency 1 cycle (registered victim). Hit/fill/inv updates take effect next cycle.
// No backpressure: every query_valid produces exactly one response one cycle later.
// Ports: hit_*/fill_*/inv_* update events; query_* request; victim_* registered response.
module lfu_replacer
    import lfu_pkg::*;
#(
    parameter int NUM_WAYS  = 4,
    parameter int NUM_SETS  = 16,
    parameter int COUNTER_W = 4,
    localparam int SET_W    = idx_width(NUM_SETS),
    localparam int WAY_W    = idx_width(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit_valid,
    input  logic [SET_W-1:0] hit_set,
    input  logic [WAY_W-1:0] hit_way,
    input  logic             fill_valid,
    input  logic [SET_W-1:0] fill_set,
    input  logic [WAY_W-1:0] fill_way,
    input  logic             inv_valid,
    input  logic [SET_W-1:0] inv_set,
    input  logic [WAY_W-1:0] inv_way,
    input  logic             query_valid,
    input  logic [SET_W-1:0] query_set,
    output logic             victim_valid,
    output logic [WAY_W-1:0] victim_way,
    output logic             victim_free
);
    localparam logic [COUNTER_W-1:0] CMAX = '1;
    localparam logic [COUNTER_W-1:0] AGED = (CMAX >> 1) + 1'b1;

    logic [NUM_WAYS-1:0][COUNTER_W-1:0] cnt_q [NUM_SETS];
    logic [NUM_WAYS-1:0][COUNTER_W-1:0] cnt_d [NUM_SETS];
    logic [NUM_WAYS-1:0]                vld_q [NUM_SETS];
    logic [NUM_WAYS-1:0]                vld_d [NUM_SETS];

    ev_t                 ev  [NUM_SETS][NUM_WAYS];
    logic [NUM_SETS-1:0] age;

    // Winning event per set/way. Later assignments override earlier ones,
    // which yields inv > fill > hit.
    always_comb begin
        for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                ev[s][w] = EV_NONE;
                if (hit_valid && hit_set == SET_W'(s) && hit_way == WAY_W'(w))
                    ev[s][w] = EV_HIT;
                if (fill_valid && fill_set == SET_W'(s) && fill_way == WAY_W'(w))
                    ev[s][w] = EV_FILL;
                if (inv_valid && inv_set == SET_W'(s) && inv_way == WAY_W'(w))
                    ev[s][w] = EV_INV;
            end
        end
    end

    // A set ages when its surviving hit lands on a valid, saturated counter.
    // A hit masked by a same-way fill/inv does not count.
    always_comb begin
        for (int s = 0; s < NUM_SETS; s++) begin
            age[s] = (ev[s][hit_way] == EV_HIT) && hit_set == SET_W'(s) &&
                     vld_q[s][hit_way] && (cnt_q[s][hit_way] == CMAX);
        end
    end

    always_comb begin
        for (int s = 0; s < NUM_SETS; s++) begin
            cnt_d[s] = cnt_q[s];
            vld_d[s] = vld_q[s];
            for (int w = 0; w < NUM_WAYS; w++) begin
                case (ev[s][w])
                    EV_INV: begin
                        cnt_d[s][w] = '0;
                        vld_d[s][w] = 1'b0;
                    end
                    EV_FILL: begin
                        cnt_d[s][w] = COUNTER_W'(1);
                        vld_d[s][w] = 1'b1;
                    end
                    default: begin
                        if (age[s]) begin
                            // Halving keeps relative order while freeing
                            // headroom; the hit way lands just above half.
                            if (hit_way == WAY_W'(w))
                                cnt_d[s][w] = AGED;
                            else if (vld_q[s][w])
                                cnt_d[s][w] = cnt_q[s][w] >> 1;
                        end else if (ev[s][w] == EV_HIT && vld_q[s][w] &&
                                     cnt_q[s][w] != CMAX) begin
                            cnt_d[s][w] = cnt_q[s][w] + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                cnt_q[s] <= '0;
                vld_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SETS; s++) begin
                cnt_q[s] <= cnt_d[s];
                vld_q[s] <= vld_d[s];
            end
        end
    end

    // The victim is selected from pre-update state of the queried row.
    logic [WAY_W-1:0] pick_way;
    logic             pick_free;

    lfu_argmin #(
        .NUM_WAYS  (NUM_WAYS),
        .COUNTER_W (COUNTER_W)
    ) u_argmin (
        .valid (vld_q[query_set]),
        .cnt   (cnt_q[query_set]),
        .way   (pick_way),
        .free  (pick_free)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            victim_valid <= 1'b0;
            victim_way   <= '0;
            victim_free  <= 1'b0;
        end else begin
            victim_valid <= query_valid;
            if (query_valid) begin
                victim_way  <= pick_way;
                victim_free <= pick_free;
            end
        end
    end

endmodule

// File: tb/tb_lfu_replacer.sv
module tb_lfu_replacer;
    localparam int SET_W = 4;
    localparam int WAY_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             hit_valid = 1'b0;
    logic [SET_W-1:0] hit_set = '0;
    logic [WAY_W-1:0] hit_way = '0;
    logic             fill_valid = 1'b0;
    logic [SET_W-1:0] fill_set = '0;
    logic [WAY_W-1:0] fill_way = '0;
    logic             inv_valid = 1'b0;
    logic [SET_W-1:0] inv_set = '0;
    logic [WAY_W-1:0] inv_way = '0;
    logic             query_valid = 1'b0;
    logic [SET_W-1:0] query_set = '0;
    logic             victim_valid;
    logic [WAY_W-1:0] victim_way;
    logic             victim_free;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lfu_replacer #(.NUM_WAYS(4), .NUM_SETS(16), .COUNTER_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .hit_valid    (hit_valid),
        .hit_set      (hit_set),
        .hit_way      (hit_way),
        .fill_valid   (fill_valid),
        .fill_set     (fill_set),
        .fill_way     (fill_way),
        .inv_valid    (inv_valid),
        .inv_set      (inv_set),
        .inv_way      (inv_way),
        .query_valid  (query_valid),
        .query_set    (query_set),
        .victim_valid (victim_valid),
        .victim_way   (victim_way),
        .victim_free  (victim_free)
    );

    // Stimulus drivers: inputs change on the falling edge; after one call the
    // rising edge that consumed them has passed and outputs are stable.
    task automatic cycle();
        @(negedge clk);
        hit_valid   = 1'b0;
        fill_valid  = 1'b0;
        inv_valid   = 1'b0;
        query_valid = 1'b0;
    endtask

    task automatic do_hit(input int s, input int w, input int n);
        for (int i = 0; i < n; i++) begin
            hit_valid = 1'b1; hit_set = SET_W'(s); hit_way = WAY_W'(w);
            cycle();
        end
    endtask

    task automatic do_fill(input int s, input int w);
        fill_valid = 1'b1; fill_set = SET_W'(s); fill_way = WAY_W'(w);
        cycle();
    endtask

    task automatic fill_all(input int s);
        for (int w = 0; w < 4; w++) do_fill(s, w);
    endtask

    task automatic do_query(input int s);
        query_valid = 1'b1; query_set = SET_W'(s);
        cycle();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (victim_valid !== 1'b0 || victim_way !== 2'd0 || victim_free !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b w=%0d f=%b exp v=0 w=0 f=0",
                     victim_valid, victim_way, victim_free);
        end
        rst = 1'b0;
        cycle();
        do_query(3);
        checks++;
        if (victim_valid !== 1'b1 || victim_way !== 2'd0 || victim_free !== 1'b1) begin
            failures++;
            $display("FAIL reset_query got v=%b w=%0d f=%b exp v=1 w=0 f=1",
                     victim_valid, victim_way, victim_free);
        end
        cycle();
        checks++;
        if (victim_valid !== 1'b0 || victim_way !== 2'd0 || victim_free !== 1'b1) begin
            failures++;
            $display("FAIL hold_idle got v=%b w=%0d f=%b exp v=0 w=0 f=1",
                     victim_valid, victim_way, victim_free);
        end
    endtask

    // Counters after: {4,2,3,3}
    task automatic test_min_count();
        fill_all(5);
        do_hit(5, 0, 3);
        do_hit(5, 1, 1);
        do_hit(5, 2, 2);
        do_hit(5, 3, 2);
        do_query(5);
        checks++;
        if (victim_valid !== 1'b1 || victim_way !== 2'd1 || victim_free !== 1'b0) begin
            failures++;
            $display("FAIL min_count got v=%b w=%0d f=%b exp v=1 w=1 f=0",
                     victim_valid, victim_way, victim_free);
        end
    endtask

    // Build {15,8,6,3}, age via a hit on way0 with a same-cycle fill of way3:
    // result {8,4,3,1}. Two hits on way3 then give {8,4,3,3} -> way2 wins the tie.
    task automatic test_aging();
        fill_all(2);
        do_hit(2, 0, 14);
        do_hit(2, 1, 7);
        do_hit(2, 2, 5);
        do_hit(2, 3, 2);
        do_query(2);
        checks++;
        if (victim_way !== 2'd3 || victim_free !== 1'b0) begin
            failures++;
            $display("FAIL pre_age got w=%0d f=%b exp w=3 f=0", victim_way, victim_free);
        end
        hit_valid = 1'b1; hit_set = 4'd2; hit_way = 2'd0;
        fill_valid = 1'b1; fill_set = 4'd2; fill_way = 2'd3;
        cycle();
        do_query(2);
        checks++;
        if (victim_way !== 2'd3 || victim_free !== 1'b0) begin
            failures++;
            $display("FAIL post_age got w=%0d f=%b exp w=3 f=0", victim_way, victim_free);
        end
        do_hit(2, 3, 2);
        do_query(2);
        checks++;
        if (victim_way !== 2'd2 || victim_free !== 1'b0) begin
            failures++;
            $display("FAIL aged_values got w=%0d f=%b exp w=2 f=0", victim_way, victim_free);
        end
    endtask

    task automatic test_priority();
        // Set 1: {3,2,3,3}; fill+hit on way1 together must leave it at 1.
        fill_all(1);
        do_hit(1, 0, 2);
        do_hit(1, 1, 1);
        do_hit(1, 2, 2);
        do_hit(1, 3, 2);
        hit_valid = 1'b1; hit_set = 4'd1; hit_way = 2'd1;
        fill_valid = 1'b1; fill_set = 4'd1; fill_way = 2'd1;
        cycle();
        do_hit(1, 1, 1);
        do_hit(1, 0, 1);
        // {4,2,3,3}: way1 was reset to 1 then hit once -> 2.
        do_query(1);
        checks++;
        if (victim_way !== 2'd1 || victim_free !== 1'b0) begin
            failures++;
            $display("FAIL fill_over_hit got w=%0d f=%b exp w=1 f=0", victim_way, victim_free);
        end
        hit_valid = 1'b1;  hit_set = 4'd1;  hit_way = 2'd2;
        fill_valid = 1'b1; fill_set = 4'd1; fill_way = 2'd2;
        inv_valid = 1'b1;  inv_set = 4'd1;  inv_way = 2'd2;
        cycle();
        do_query(1);
        checks++;
        if (victim_way !== 2'd2 || victim_free !== 1'b1) begin
            failures++;
            $display("FAIL inv_wins got w=%0d f=%b exp w=2 f=1", victim_way, victim_free);
        end
        do_hit(1, 2, 3);
        do_query(1);
        checks++;
        if (victim_way !== 2'd2 || victim_free !== 1'b1) begin
            failures++;
            $display("FAIL hit_invalid got w=%0d f=%b exp w=2 f=1", victim_way, victim_free);
        end
    endtask

    task automatic test_pre_update();
        fill_all(7);
        do_hit(7, 0, 1);
        do_hit(7, 2, 1);
        do_hit(7, 3, 1);
        query_valid = 1'b1; query_set = 4'd7;
        inv_valid = 1'b1; inv_set = 4'd7; inv_way = 2'd0;
        cycle();
        checks++;
        if (victim_valid !== 1'b1 || victim_way !== 2'd1 || victim_free !== 1'b0) begin
            failures++;
            $display("FAIL pre_update got v=%b w=%0d f=%b exp v=1 w=1 f=0",
                     victim_valid, victim_way, victim_free);
        end
        do_query(7);
        checks++;
        if (victim_way !== 2'd0 || victim_free !== 1'b1) begin
            failures++;
            $display("FAIL post_inv got w=%0d f=%b exp w=0 f=1", victim_way, victim_free);
        end
    endtask

    task automatic test_parallel();
        fill_all(10);
        hit_valid = 1'b1;  hit_set = 4'd10; hit_way = 2'd0;
        inv_valid = 1'b1;  inv_set = 4'd10; inv_way = 2'd3;
        fill_valid = 1'b1; fill_set = 4'd12; fill_way = 2'd1;
        cycle();
        do_query(10);
        checks++;
        if (victim_way !== 2'd3 || victim_free !== 1'b1) begin
            failures++;
            $display("FAIL par_inv got w=%0d f=%b exp w=3 f=1", victim_way, victim_free);
        end
        do_fill(10, 3);
        // set 10 now {2,1,1,1}
        do_query(10);
        checks++;
        if (victim_way !== 2'd1 || victim_free !== 1'b0) begin
            failures++;
            $display("FAIL par_hit got w=%0d f=%b exp w=1 f=0", victim_way, victim_free);
        end
        do_query(12);
        checks++;
        if (victim_way !== 2'd0 || victim_free !== 1'b1) begin
            failures++;
            $display("FAIL par_fill got w=%0d f=%b exp w=0 f=1", victim_way, victim_free);
        end
    endtask

    task automatic test_back_to_back();
        // Set 5 is {4,2,3,3} -> way1; set 12 has only way1 -> way0 free.
        query_valid = 1'b1; query_set = 4'd5;
        @(negedge clk);
        checks++;
        if (victim_valid !== 1'b1 || victim_way !== 2'd1 || victim_free !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first got v=%b w=%0d f=%b exp v=1 w=1 f=0",
                     victim_valid, victim_way, victim_free);
        end
        query_set = 4'd12;
        cycle();
        checks++;
        if (victim_valid !== 1'b1 || victim_way !== 2'd0 || victim_free !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second got v=%b w=%0d f=%b exp v=1 w=0 f=1",
                     victim_valid, victim_way, victim_free);
        end
    endtask

    task automatic test_mid_reset();
        fill_all(9);
        query_valid = 1'b1; query_set = 4'd9;
        #2 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (victim_valid !== 1'b0 || victim_way !== 2'd0 || victim_free !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got v=%b w=%0d f=%b exp v=0 w=0 f=0",
                     victim_valid, victim_way, victim_free);
        end
        query_valid = 1'b0;
        rst = 1'b0;
        cycle();
        checks++;
        if (victim_valid !== 1'b0) begin
            failures++;
            $display("FAIL spurious_resp got v=%b exp v=0", victim_valid);
        end
        do_query(9);
        checks++;
        if (victim_valid !== 1'b1 || victim_way !== 2'd0 || victim_free !== 1'b1) begin
            failures++;
            $display("FAIL cleared_set9 got v=%b w=%0d f=%b exp v=1 w=0 f=1",
                     victim_valid, victim_way, victim_free);
        end
        do_query(5);
        checks++;
        if (victim_way !== 2'd0 || victim_free !== 1'b1) begin
            failures++;
            $display("FAIL cleared_set5 got w=%0d f=%b exp w=0 f=1", victim_way, victim_free);
        end
    endtask

    initial begin
        test_reset();
        test_min_count();
        test_aging();
        test_priority();
        test_pre_update();
        test_parallel();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout exceeded 200000 time units");
        $fatal(1);
    end

endmodule
